// File: rtl/uart_frame_receiver_pkg.sv
// uart_pkg: shared UART state encoding, bit timing helper and default frame width
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} rx_state_e;
  typedef struct packed {
    int clks_per_bit;
    int half_bit;
  } bit_timing_t;
  localparam int DEFAULT_NUM_DATA_BITS = 8;
  function automatic bit_timing_t bit_timing(input int clk_freq_hz, input int baud_rate);
    bit_timing_t t;
    t.clks_per_bit = clk_freq_hz / baud_rate;
    t.half_bit = t.clks_per_bit / 2;
    return t;
  endfunction
endpackage

// File: rtl/uart_frame_receiver_sync.sv
// signal_synchronizer: two-flop synchronizer with configurable reset level
module signal_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk)
    if (rst) sync_q <= {2{RESET_VAL}};
    else sync_q <= {sync_q[0], d};
  assign q = sync_q[1];
endmodule

// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver: mid-bit sampling 8N1-style UART receiver with framing check
module uart_frame_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 12_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     rx_in,
  output logic [NUM_DATA_BITS-1:0] data_out,
  output logic                     data_ready,
  output logic                     frame_error,
  output logic                     rx_busy
);
  localparam bit_timing_t TIMING = bit_timing(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CPB = TIMING.clks_per_bit;
  localparam int HALF = TIMING.half_bit;
  localparam int CW = $clog2(CPB);
  localparam int IW = $clog2(NUM_DATA_BITS + 1);
  logic rx_s, bit_end, half_end;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic ready_q, ready_d, ferr_q, ferr_d, busy_q, busy_d;
  signal_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk(sys_clk),
    .rst(rst),
    .d(rx_in),
    .q(rx_s)
  );
  // next-state logic: start validation at half bit, data/stop sampling at bit end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = data_q;
    ready_d = 1'b0;
    ferr_d = 1'b0;
    bit_end = cnt_q == CW'(CPB - 1);
    half_end = cnt_q == CW'(HALF - 1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (half_end) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[NUM_DATA_BITS-1:1]};
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IW'(NUM_DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        cnt_d = '0;
        ready_d = rx_s;
        ferr_d = !rx_s;
        data_d = rx_s ? shift_q : data_q;
        state_d = rx_s ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : BREAK_WAIT;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end
  // register FSM state, datapath and outputs
  always_ff @(posedge sys_clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      ready_q <= ready_d;
      ferr_q <= ferr_d;
      busy_q <= busy_d;
    end
  assign data_out = data_q;
  assign data_ready = ready_q;
  assign frame_error = ferr_q;
  assign rx_busy = busy_q;
endmodule
